// File: rtl/dec_scan.sv
// Registered N-to-2^N one-hot decoder with enable and an auto-scan mode.
// DECODE registers the one-hot image of a; SCAN steps through every output, holding each for DWELL cycles.
module dec_scan #(
   parameter int N     = 2,
   parameter int DWELL = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             e,
   input  logic             mode,
   input  logic [N-1:0]     a,
   output logic [2**N-1:0]  y,
   output logic [N-1:0]     idx,
   output logic             wrap
);

   localparam int M  = 2**N;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_DEC  = 2'd1,
      ST_SCAN = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [N-1:0]    idx_nxt;
   logic [M-1:0]    y_nxt;
   logic            wrap_nxt;
   logic            scan_stay;
   logic            scan_step;

   // State register together with all output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_OFF;
         cnt   <= '0;
         idx   <= '0;
         y     <= '0;
         wrap  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         idx   <= idx_nxt;
         y     <= y_nxt;
         wrap  <= wrap_nxt;
      end
   end

   always_comb begin
      state_nxt = ST_OFF;
      if (e) begin
         state_nxt = mode ? ST_SCAN : ST_DEC;
      end
   end

   // Entry into SCAN (from OFF or DEC) seeds from a; only a stay in SCAN advances the dwell.
   assign scan_stay = (state == ST_SCAN) && (state_nxt == ST_SCAN);
   assign scan_step = scan_stay && (cnt == CNT_LAST);

   always_comb begin
      cnt_nxt  = '0;
      idx_nxt  = idx;
      wrap_nxt = 1'b0;
      y_nxt    = '0;
      case (state_nxt)
         ST_DEC: begin
            idx_nxt = a;
         end
         ST_SCAN: begin
            if (!scan_stay) begin
               idx_nxt = a;
            end else if (scan_step) begin
               idx_nxt  = idx + 1'b1;
               wrap_nxt = &idx;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            idx_nxt = idx;
         end
      endcase
      if (state_nxt != ST_OFF) begin
         y_nxt[idx_nxt] = 1'b1;
      end
   end

   // y is either dark or exactly one-hot on idx.
   a_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y));
   a_y_idx   : assert property (@(posedge clk) disable iff (!rst_n) (y == '0) || y[idx]);
   a_wrap_y0 : assert property (@(posedge clk) disable iff (!rst_n) wrap |-> (idx == '0) && y[0]);

endmodule
